// File: rtl/tally_display_pkg.sv
// -----------------------------------------------------------------------------
// tally_display_pkg
//   Shared types and helpers for the result-phase tally display.
//   - state_t   : display sequencer states (BLANK, CONVERT, SHOW)
//   - SEG_BLANK : all segments off (active-low)
//   - SEG_DASH  : only segment g lit, used for the overflow indication
//   - seg7()    : BCD digit to active-low {g..a} segment pattern; values above
//                 9 give a blank digit
//   - pow10()   : 10^d, used to size the overflow threshold at elaboration
// -----------------------------------------------------------------------------
package tally_display_pkg;

    typedef enum logic [1:0] {
        BLANK   = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/tally_display_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock).
//   A load captures bin and clears the BCD accumulator; the following W clocks
//   each shift one bit in, and done pulses for one cycle after the last shift,
//   with bcd holding the final result during that cycle.
//   Values that do not fit in DIGITS digits are truncated; the caller detects
//   that case on its own.
//
// Ports
//   clock    in   system clock
//   reset_n  in   asynchronous active-low reset
//   clr      in   synchronous abort: drops any conversion in flight
//   load     in   start a conversion of bin (ignored while clr is high)
//   bin      in   W-bit binary value
//   done     out  one-cycle pulse, conversion finished
//   bcd      out  DIGITS packed BCD digits, least significant in [3:0]
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [W-1:0]          bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]        shift_q;
    logic [CW-1:0]       left_q;
    logic                active_q;
    logic [4*DIGITS-1:0] adj;

    // Add 3 to every digit that is 5 or more before the next doubling, so the
    // shift carries correctly into the next decimal digit.
    always_comb begin
        adj = bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_q  <= '0;
            left_q   <= '0;
            active_q <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                shift_q  <= '0;
                left_q   <= '0;
                active_q <= 1'b0;
                bcd      <= '0;
            end else if (load) begin
                shift_q  <= bin;
                left_q   <= CW'(W);
                active_q <= 1'b1;
                bcd      <= '0;
            end else if (active_q) begin
                bcd     <= {adj[4*DIGITS-2:0], shift_q[W-1]};
                shift_q <= shift_q << 1;
                left_q  <= left_q - 1'b1;
                if (left_q == CW'(1)) begin
                    active_q <= 1'b0;
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tally_display.sv
// -----------------------------------------------------------------------------
// tally_display
//   Result-phase display sequencer. Steps through N_CAND tally channels and
//   shows each channel's two-digit code and its count in decimal on 7-segment
//   digits (active-low {g..a}). Each step snapshots the target channel's count,
//   converts it to BCD one bit per clock and then updates index, all segment
//   outputs and overflow in one edge, so the display never shows a partial
//   result.
//
// Ports
//   clock        in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   synchronous clear: blank everything, back to channel 0
//   show         in   step request, only rising edges act
//   auto_en      in   auto-step every AUTO_TICKS cycles while showing
//   counts       in   flattened counts, channel i at [CNT_W*i +: CNT_W]
//   seg_code_hi  out  code tens digit
//   seg_code_lo  out  code units digit
//   seg_count    out  count digits, most significant in the top 7 bits
//   index        out  channel currently displayed
//   busy         out  high while a conversion is in flight
//   overflow     out  displayed count does not fit in DIGITS digits
//   fsm_state    out  sequencer state, for observation
//
// Handshake: a step is show=1 while the registered copy of show is 0. Steps
// and auto-ticks arriving while busy is high are dropped, not queued; start
// wins over any simultaneous step.
// -----------------------------------------------------------------------------
module tally_display
    import tally_display_pkg::*;
#(
    parameter int                    N_CAND     = 3,
    parameter int                    CNT_W      = 8,
    parameter int                    DIGITS     = 3,
    parameter logic [8*N_CAND-1:0]   CODES      = 24'h00_22_13,
    parameter int                    AUTO_TICKS = 50_000_000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic                        show,
    input  logic                        auto_en,
    input  logic [N_CAND*CNT_W-1:0]     counts,
    output logic [6:0]                  seg_code_hi,
    output logic [6:0]                  seg_code_lo,
    output logic [DIGITS*7-1:0]         seg_count,
    output logic [$clog2(N_CAND)-1:0]   index,
    output logic                        busy,
    output logic                        overflow,
    output state_t                      fsm_state
);

    localparam int                IDX_W     = $clog2(N_CAND);
    localparam int                TICK_W    = $clog2(AUTO_TICKS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_CAND - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_TICKS - 1);
    // Largest value that fits in DIGITS decimal digits; counts up to 64 bits.
    localparam logic [63:0]       COUNT_MAX = pow10(DIGITS) - 64'd1;

    state_t              state;
    logic                show_q;
    logic [IDX_W-1:0]    target_q;
    logic                ovf_q;
    logic [TICK_W-1:0]   tick_q;

    logic                step;
    logic                tick_fire;
    logic                accept;
    logic [IDX_W-1:0]    next_target;
    logic [CNT_W-1:0]    sel_count;
    logic                sel_ovf;
    logic                conv_done;
    logic [4*DIGITS-1:0] bcd;
    logic [7:0]          code_byte;
    logic [DIGITS*7-1:0] count_segs;

    assign fsm_state = state;

    assign step      = show & ~show_q;
    assign tick_fire = auto_en && (tick_q == TICK_LAST);

    // A conversion starts only from BLANK (on a step) or SHOW (on a step or an
    // auto-tick). start suppresses it so the converter is never loaded on the
    // same edge that it is cleared.
    assign accept = !start &&
                    (((state == BLANK) && step) ||
                     ((state == SHOW) && (step || tick_fire)));

    // From BLANK the first channel shown is 0; from SHOW it is the next one,
    // wrapping after the last channel.
    always_comb begin
        next_target = '0;
        if ((state == SHOW) && (index != LAST_IDX)) begin
            next_target = index + 1'b1;
        end
    end

    always_comb begin
        sel_count = counts[CNT_W*int'(next_target) +: CNT_W];
        sel_ovf   = 64'(sel_count) > COUNT_MAX;
    end

    // Display patterns for the channel under conversion, registered only when
    // the converter reports done.
    always_comb begin
        code_byte = CODES[8*int'(target_q) +: 8];
        for (int d = 0; d < DIGITS; d++) begin
            count_segs[7*d +: 7] = ovf_q ? SEG_DASH : seg7(bcd[4*d +: 4]);
        end
    end

    bin2bcd_seq #(
        .W      (CNT_W),
        .DIGITS (DIGITS)
    ) u_conv (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (start),
        .load    (accept),
        .bin     (sel_count),
        .done    (conv_done),
        .bcd     (bcd)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BLANK;
            show_q      <= 1'b0;
            target_q    <= '0;
            ovf_q       <= 1'b0;
            tick_q      <= '0;
            index       <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
            seg_code_hi <= SEG_BLANK;
            seg_code_lo <= SEG_BLANK;
            seg_count   <= {DIGITS{SEG_BLANK}};
        end else begin
            show_q <= show;
            if (start) begin
                state       <= BLANK;
                target_q    <= '0;
                ovf_q       <= 1'b0;
                tick_q      <= '0;
                index       <= '0;
                busy        <= 1'b0;
                overflow    <= 1'b0;
                seg_code_hi <= SEG_BLANK;
                seg_code_lo <= SEG_BLANK;
                seg_count   <= {DIGITS{SEG_BLANK}};
            end else begin
                case (state)
                    BLANK: begin
                        if (accept) begin
                            state    <= CONVERT;
                            busy     <= 1'b1;
                            target_q <= next_target;
                            ovf_q    <= sel_ovf;
                        end
                    end
                    CONVERT: begin
                        // Outputs hold their old values until this edge.
                        if (conv_done) begin
                            state       <= SHOW;
                            busy        <= 1'b0;
                            index       <= target_q;
                            seg_code_hi <= seg7(code_byte[7:4]);
                            seg_code_lo <= seg7(code_byte[3:0]);
                            seg_count   <= count_segs;
                            overflow    <= ovf_q;
                            tick_q      <= '0;
                        end
                    end
                    SHOW: begin
                        if (accept) begin
                            state    <= CONVERT;
                            busy     <= 1'b1;
                            target_q <= next_target;
                            ovf_q    <= sel_ovf;
                        end else if (!auto_en) begin
                            tick_q <= '0;
                        end else begin
                            tick_q <= tick_q + 1'b1;
                        end
                    end
                    default: begin
                        state <= BLANK;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tally_display.sv
// -----------------------------------------------------------------------------
// tb_tally_display
//   Directed bench for tally_display with CNT_W=10, DIGITS=3, AUTO_TICKS=20.
//   Expected display words are computed from decimal arithmetic and a local
//   segment table, queued when a step is driven and compared when busy falls.
// -----------------------------------------------------------------------------
module tb_tally_display;
    import tally_display_pkg::*;

    localparam int N_CAND     = 3;
    localparam int CNT_W      = 10;
    localparam int DIGITS     = 3;
    localparam int AUTO_TICKS = 20;
    localparam int IDX_W      = 2;
    localparam int EW         = IDX_W + 7 + 7 + DIGITS*7 + 1;
    localparam int LAT        = CNT_W + 1;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic                      start;
    logic                      show;
    logic                      auto_en;
    logic [N_CAND*CNT_W-1:0]   counts;
    logic [6:0]                seg_code_hi;
    logic [6:0]                seg_code_lo;
    logic [DIGITS*7-1:0]       seg_count;
    logic [IDX_W-1:0]          index;
    logic                      busy;
    logic                      overflow;
    state_t                    fsm_state;

    tally_display #(
        .N_CAND     (N_CAND),
        .CNT_W      (CNT_W),
        .DIGITS     (DIGITS),
        .CODES      (24'h00_22_13),
        .AUTO_TICKS (AUTO_TICKS)
    ) dut (
        .clock       (clk),
        .reset_n     (rst_n),
        .start       (start),
        .show        (show),
        .auto_en     (auto_en),
        .counts      (counts),
        .seg_code_hi (seg_code_hi),
        .seg_code_lo (seg_code_lo),
        .seg_count   (seg_count),
        .index       (index),
        .busy        (busy),
        .overflow    (overflow),
        .fsm_state   (fsm_state)
    );

    // ---------------- reference data ----------------
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    logic [7:0] code_tab [N_CAND] = '{8'h13, 8'h22, 8'h00};

    int  model_cnt [N_CAND];
    int  model_idx;
    bit  model_blank;

    logic [EW-1:0] exp_q[$];
    int checks;
    int errors;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] observe();
        return {index, seg_code_hi, seg_code_lo, seg_count, overflow};
    endfunction

    function automatic logic [EW-1:0] model_out(input int ch, input int v);
        logic [6:0]          hi;
        logic [6:0]          lo;
        logic [DIGITS*7-1:0] cs;
        logic [7:0]          code;
        logic                ovf;
        int                  p;
        code = code_tab[ch];
        hi   = seg_tab[int'(code[7:4])];
        lo   = seg_tab[int'(code[3:0])];
        ovf  = (v > 999);
        p    = 1;
        for (int d = 0; d < DIGITS; d++) begin
            cs[7*d +: 7] = ovf ? 7'b0111111 : seg_tab[(v / p) % 10];
            p = p * 10;
        end
        return {IDX_W'(ch), hi, lo, cs, ovf};
    endfunction

    task automatic pop_compare(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=no-entry expected=queued-result", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(observe()), 64'(e));
        end
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_hi"},    64'(seg_code_hi), 64'h7F);
        check({tag, "_lo"},    64'(seg_code_lo), 64'h7F);
        check({tag, "_count"}, 64'(seg_count),   64'h1F_FFFF);
        check({tag, "_index"}, 64'(index),       64'd0);
        check({tag, "_busy"},  64'(busy),        64'd0);
        check({tag, "_ovf"},   64'(overflow),    64'd0);
        check({tag, "_state"}, 64'(fsm_state),   64'(BLANK));
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_count(input int ch, input int v);
        model_cnt[ch] = v;
        counts[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Waits (bounded) at negedges until busy drops; n = negedges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    function automatic void advance_model();
        if (model_blank) model_idx = 0;
        else             model_idx = (model_idx + 1) % N_CAND;
        model_blank = 1'b0;
    endfunction

    // Called at a negedge. Drives a step, checks busy and latency, then the
    // result. With hold=1 show is left high on return.
    task automatic do_step(input string tag, input bit hold);
        int n;
        advance_model();
        exp_q.push_back(model_out(model_idx, model_cnt[model_idx]));
        show = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, 64'(busy), 64'd1);
        if (!hold) show = 1'b0;
        wait_done(n);
        check({tag, "_latency"}, 64'(n), 64'(LAT));
        pop_compare(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int            n;
        int            k;
        bit            saw_busy;
        logic [EW-1:0] prev;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        start = 1'b0;
        show = 1'b0;
        auto_en = 1'b0;
        counts = '0;
        model_blank = 1'b1;
        model_idx = 0;
        for (int i = 0; i < N_CAND; i++) model_cnt[i] = 0;

        repeat (3) @(negedge clk);
        check_blank("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_blank("post_reset");

        // Basic walk through all channels and wrap.
        set_count(0, 120);
        set_count(1, 45);
        set_count(2, 7);
        do_step("ch0", 1'b0);
        do_step("ch1", 1'b0);
        do_step("ch2", 1'b0);
        do_step("wrap_ch0", 1'b0);

        // show held high for 20 cycles advances exactly once.
        do_step("hold_ch1", 1'b1);
        repeat (8) @(negedge clk);
        check("hold_busy", 64'(busy), 64'd0);
        check("hold_index", 64'(index), 64'(model_idx));
        show = 1'b0;
        @(negedge clk);
        check("hold_release_busy", 64'(busy), 64'd0);

        // Overflow and its clearing on the next channel.
        set_count(2, 1000);
        set_count(0, 999);
        do_step("ovf_ch2", 1'b0);
        check("ovf_flag", 64'(overflow), 64'd1);
        do_step("ovf_clear_ch0", 1'b0);
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Step and count change during CONVERT: step dropped, snapshot kept.
        prev = observe();
        advance_model();
        exp_q.push_back(model_out(model_idx, model_cnt[model_idx]));
        show = 1'b1;
        @(negedge clk);
        check("mid_busy0", 64'(busy), 64'd1);
        show = 1'b0;
        repeat (2) @(negedge clk);
        set_count(1, 500);
        show = 1'b1;
        @(negedge clk);
        show = 1'b0;
        k = 3;
        check("mid_hold_out", 64'(observe()), 64'(prev));
        check("mid_busy1", 64'(busy), 64'd1);
        wait_done(n);
        check("mid_latency", 64'(k + n), 64'(LAT));
        pop_compare("snapshot_ch1");
        saw_busy = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("dropped_step", 64'(saw_busy), 64'd0);
        check("dropped_index", 64'(index), 64'(model_idx));

        // start mid-CONVERT aborts and blanks one edge later.
        show = 1'b1;
        @(negedge clk);
        show = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_blank("abort");
        model_blank = 1'b1;
        repeat (CNT_W + 5) @(negedge clk);
        check_blank("abort_hold");

        // start wins over a simultaneous step.
        do_step("restart_ch0", 1'b0);
        start = 1'b1;
        show = 1'b1;
        @(negedge clk);
        start = 1'b0;
        show = 1'b0;
        check_blank("start_prio");
        model_blank = 1'b1;
        repeat (CNT_W + 3) @(negedge clk);
        check_blank("start_prio_hold");

        // Auto-scroll: 20 ticks in SHOW, then the conversion latency.
        do_step("auto_base", 1'b0);
        auto_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            advance_model();
            exp_q.push_back(model_out(model_idx, model_cnt[model_idx]));
            n = 0;
            while (busy !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("auto_fire", 64'(n), 64'(AUTO_TICKS));
            wait_done(n);
            check("auto_conv", 64'(n), 64'(LAT));
            pop_compare("auto_result");
        end
        auto_en = 1'b0;
        prev = observe();
        saw_busy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("frozen_busy", 64'(saw_busy), 64'd0);
        check("frozen_out", 64'(observe()), 64'(prev));

        // Asynchronous reset in SHOW blanks without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_blank("reset_release");
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
